// File: rtl/uart_mmio_hub.sv
// uart_mmio_hub
//   UART MMIO hub between the core data bus, the instruction-memory loader
//   and UartRx/UartTx.
//   Boot: a 4-byte little-endian word count N (clamped to MAX_INSTR) arrives
//   first. N 32-bit little-endian words follow, and each one is written to
//   instruction memory at CODE_BASE+k.
//   Run: rx bytes go into a ring FIFO. Tx bytes go into a holding register,
//   or into a TX_DEPTH FIFO when UART_HUB_TX_FIFO_EN is defined.
//   Both are exposed as MMIO. Accesses that cannot complete (pop on empty,
//   push on full, any access during boot) stall the core.
// Ports
//   clock, reset          sole clock; asynchronous active-low reset
//   dbus_addr/re/we/wd    data-bus request (addr[31]=1 selects MMIO, offset addr[3:0])
//   dbus_rd, dbus_stall   combinational read data and stall
//   rx_valid, rx_data     byte strobe from UartRx
//   tx_start, tx_data     one-cycle launch to UartTx; tx_busy from UartTx
//   imem_we/addr/wd       instruction-memory write port
//   boot_done             high once all N boot words are written
// Configuration macro: UART_HUB_TX_FIFO_EN (tx FIFO instead of holding register)
module uart_mmio_hub #(
  parameter int RX_DEPTH  = 256,
  parameter int TX_DEPTH  = 16,
  parameter int CODE_BASE = 0,
  parameter int MAX_INSTR = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dbus_addr,
  input  logic        dbus_re,
  input  logic        dbus_we,
  input  logic [31:0] dbus_wd,
  output logic [31:0] dbus_rd,
  output logic        dbus_stall,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        boot_done
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam logic [31:0] CODE_BASE_W = 32'(CODE_BASE);
  localparam logic [31:0] MAX_W       = 32'(MAX_INSTR);

  localparam logic [1:0] ST_LEN  = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_q;
  logic [31:0] n_words;
  logic [31:0] word_idx;
  logic [31:0] word_full;
  logic [31:0] n_clamped;

  // Bytes shift in from the top, so after four bytes the first one is the LSB.
  assign word_full = {rx_data, asm_q[31:8]};
  assign n_clamped = (word_full > MAX_W) ? MAX_W : word_full;

  // ---------------- boot loader ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_LEN;
      byte_cnt  <= 2'd0;
      asm_q     <= 32'd0;
      n_words   <= 32'd0;
      word_idx  <= 32'd0;
      imem_we   <= 1'b0;
      imem_addr <= 32'd0;
      imem_wd   <= 32'd0;
      boot_done <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      // Goes high the cycle after the FSM enters RUN.
      boot_done <= (state == ST_RUN);
      if (state != ST_RUN && rx_valid) begin
        asm_q    <= word_full;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          if (state == ST_LEN) begin
            n_words  <= n_clamped;
            word_idx <= 32'd0;
            state    <= (n_clamped == 32'd0) ? ST_RUN : ST_LOAD;
          end else begin
            imem_we   <= 1'b1;
            imem_addr <= CODE_BASE_W + word_idx;
            imem_wd   <= word_full;
            word_idx  <= word_idx + 32'd1;
            if (word_idx == n_words - 32'd1) state <= ST_RUN;
          end
        end
      end
    end
  end

  // ---------------- MMIO decode ----------------
  logic       in_run, mmio_rd, mmio_wr;
  logic [3:0] off;
  logic       rx_empty, rx_full;
  logic       pop_req, pop_fire, pop_bypass, rx_push, rx_drop, stat_clr;
  logic       push_req, tx_fire, tx_blocked, tx_launch;
  logic [7:0] tx_launch_data;
  logic [31:0] tx_space;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_head, rx_tail;
  logic [RX_CW-1:0] rx_count;
  logic             rx_sticky;

  assign in_run   = (state == ST_RUN);
  assign mmio_rd  = dbus_addr[31] & dbus_re;
  assign mmio_wr  = dbus_addr[31] & dbus_we;
  assign off      = dbus_addr[3:0];
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));

  assign pop_req    = in_run & mmio_rd & (off == 4'h1);
  assign pop_fire   = pop_req & ~rx_empty;
  // Pop on empty while a byte arrives: the byte goes straight to the core.
  assign pop_bypass = pop_req & rx_empty & rx_valid;
  assign rx_push    = in_run & rx_valid & ~pop_bypass;
  // A pop in the same cycle frees the slot, so nothing is dropped.
  assign rx_drop    = rx_push & rx_full & ~pop_fire;
  assign stat_clr   = in_run & mmio_rd & (off == 4'h0);
  assign push_req   = in_run & mmio_wr & (off == 4'h4);
  assign tx_fire    = push_req & ~tx_blocked;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    dbus_rd    = 32'd0;
    dbus_stall = 1'b0;
    if (mmio_rd || mmio_wr) begin
      if (!in_run) begin
        dbus_stall = 1'b1;
      end else begin
        if (mmio_rd) begin
          case (off)
            4'h0: dbus_rd = {30'd0, rx_sticky, boot_done};
            4'h1: begin
              if (!rx_empty)     dbus_rd = {24'd0, rx_mem[rx_head]};
              else if (rx_valid) dbus_rd = {24'd0, rx_data};
              else               dbus_stall = 1'b1;
            end
            4'h2:    dbus_rd = 32'(rx_count);
            4'h8:    dbus_rd = tx_space;
            default: dbus_rd = 32'd0;
          endcase
        end
        if (mmio_wr && off == 4'h4 && tx_blocked) dbus_stall = 1'b1;
      end
    end
  end

  // ---------------- rx ring ----------------
  // NOTE: FIFO storage has no reset; the empty/full state lives in the pointers and count.
  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_tail] <= rx_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_head   <= '0;
      rx_tail   <= '0;
      rx_count  <= '0;
      rx_sticky <= 1'b0;
    end else begin
      if (rx_push)            rx_tail <= rx_tail + RX_AW'(1);
      if (pop_fire | rx_drop) rx_head <= rx_head + RX_AW'(1);
      if (rx_push && !pop_fire && !rx_full) rx_count <= rx_count + RX_CW'(1);
      else if (pop_fire && !rx_push)        rx_count <= rx_count - RX_CW'(1);
      // An overflow in the same cycle as a status read wins over the clear.
      if (rx_drop)       rx_sticky <= 1'b1;
      else if (stat_clr) rx_sticky <= 1'b0;
    end
  end

  // ---------------- tx path ----------------
`ifdef UART_HUB_TX_FIFO_EN
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_head, tx_tail;
  logic [TX_CW-1:0] tx_count;

  assign tx_launch      = (tx_count != '0) & ~tx_busy & ~tx_start;
  // A full FIFO still accepts a push in the cycle a byte drains.
  assign tx_blocked     = (tx_count == TX_CW'(TX_DEPTH)) & ~tx_launch;
  assign tx_launch_data = tx_mem[tx_head];
  assign tx_space       = 32'(TX_DEPTH) - 32'(tx_count);

  always_ff @(posedge clock) begin
    if (tx_fire) tx_mem[tx_tail] <= dbus_wd[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_head  <= '0;
      tx_tail  <= '0;
      tx_count <= '0;
    end else begin
      if (tx_fire)   tx_tail <= tx_tail + TX_AW'(1);
      if (tx_launch) tx_head <= tx_head + TX_AW'(1);
      if (tx_fire && !tx_launch)      tx_count <= tx_count + TX_CW'(1);
      else if (tx_launch && !tx_fire) tx_count <= tx_count - TX_CW'(1);
    end
  end
`else
  // The holding-register build has no use for the FIFO depth.
  localparam int TX_DEPTH_UNUSED = TX_DEPTH;

  logic       hold_full;
  logic [7:0] hold_data;

  assign tx_launch      = hold_full & ~tx_busy & ~tx_start;
  assign tx_blocked     = hold_full | tx_busy;
  assign tx_launch_data = hold_data;
  assign tx_space       = {31'd0, ~hold_full & ~tx_busy};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_data <= 8'd0;
    end else if (tx_fire) begin
      hold_full <= 1'b1;
      hold_data <= dbus_wd[7:0];
    end else if (tx_launch) begin
      hold_full <= 1'b0;
    end
  end
`endif

  // The tx_start term in tx_launch covers UartTx's one-cycle tx_busy latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_start <= 1'b0;
      tx_data  <= 8'd0;
    end else begin
      tx_start <= tx_launch;
      if (tx_launch) tx_data <= tx_launch_data;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{dbus_addr[30:4], dbus_wd[31:8]};

endmodule

// File: tb/tb_uart_mmio_hub.sv
// tb_uart_mmio_hub
//   Directed sequence with randomized data. A queue-based model of the
//   rx FIFO, the boot words and the tx byte stream supplies every expected
//   value. A small UartTx stand-in answers tx_start with a random busy period.
module tb_uart_mmio_hub;

  localparam int RX_DEPTH  = 256;
  localparam int TX_DEPTH  = 16;
  localparam int CODE_BASE = 0;
  localparam int MAX_INSTR = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dbus_addr = 32'd0;
  logic        dbus_re = 1'b0;
  logic        dbus_we = 1'b0;
  logic [31:0] dbus_wd = 32'd0;
  logic [31:0] dbus_rd;
  logic        dbus_stall;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        boot_done;

  uart_mmio_hub #(
    .RX_DEPTH(RX_DEPTH), .TX_DEPTH(TX_DEPTH), .CODE_BASE(CODE_BASE), .MAX_INSTR(MAX_INSTR)
  ) dut (
    .clock(clock), .reset(reset),
    .dbus_addr(dbus_addr), .dbus_re(dbus_re), .dbus_we(dbus_we), .dbus_wd(dbus_wd),
    .dbus_rd(dbus_rd), .dbus_stall(dbus_stall),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd), .boot_done(boot_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // ---------------- instruction-memory monitor ----------------
  logic [63:0] imem_log[$];
  always @(posedge clock) begin
    if (imem_we) imem_log.push_back({imem_addr, imem_wd});
  end

  // ---------------- UartTx stand-in ----------------
  logic       tx_force = 1'b0;
  int         busy_cnt = 0;
  int         double_start = 0;
  logic       prev_start = 1'b0;
  logic       start_seen;
  logic [7:0] sent_q[$];

  assign tx_busy = tx_force | (busy_cnt != 0);

  always begin
    @(posedge clock);
    start_seen = tx_start;
    if (start_seen) begin
      sent_q.push_back(tx_data);
      if (prev_start) double_start++;
    end
    prev_start = start_seen;
    #1;
    if (start_seen) busy_cnt = 2 + int'($urandom_range(3));
    else if (busy_cnt > 0) busy_cnt--;
  end

  // ---------------- reference model state ----------------
  logic [7:0] rxq[$];
  bit         sticky = 1'b0;
  logic [7:0] exp_tx[$];

  task automatic rx_model_push(input logic [7:0] b);
    if (rxq.size() == RX_DEPTH) begin
      void'(rxq.pop_front());
      sticky = 1'b1;
    end
    rxq.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if ($urandom_range(1) == 1) step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);
    check("rst_imem_wd", imem_wd, 32'd0);
    check("rst_boot_done", {31'd0, boot_done}, 32'd0);
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic boot(input logic [31:0] n_raw, input int words_sent, input bit full);
    logic [31:0] w;
    logic [63:0] exp_q[$];
    imem_log.delete();
    for (int i = 0; i < 4; i++) send_byte(n_raw[8*i +: 8]);
    for (int k = 0; k < words_sent; k++) begin
      w = $urandom;
      exp_q.push_back({32'(CODE_BASE + k), w});
      for (int b = 0; b < 4; b++) begin
        if (full && k == words_sent - 1 && b == 3)
          check("boot_done_early", {31'd0, boot_done}, 32'd0);
        send_byte(w[8*b +: 8]);
      end
    end
    step();
    step();
    check("imem_count", 32'(imem_log.size()), 32'(words_sent));
    for (int k = 0; k < words_sent && k < imem_log.size(); k++) begin
      check("imem_addr", imem_log[k][63:32], exp_q[k][63:32]);
      check("imem_wd", imem_log[k][31:0], exp_q[k][31:0]);
    end
    if (full) check("boot_done", {31'd0, boot_done}, 32'd1);
  endtask

  task automatic rd_check(input logic [3:0] offs, input logic [31:0] exp, input string tag);
    dbus_addr = {28'h8000000, offs};
    dbus_re   = 1'b1;
    #1;
    check(tag, dbus_rd, exp);
    check("rd_no_stall", {31'd0, dbus_stall}, 32'd0);
    step();
    dbus_re   = 1'b0;
    dbus_addr = 32'd0;
  endtask

  task automatic mmio_write(input logic [3:0] offs, input logic [7:0] b, input int budget,
                            output int waited);
    dbus_addr = {28'h8000000, offs};
    dbus_wd   = {24'($urandom), b};
    dbus_we   = 1'b1;
    waited    = 0;
    #1;
    while (dbus_stall && waited < budget) begin
      step();
      #1;
      waited++;
    end
    step();
    dbus_we   = 1'b0;
    dbus_addr = 32'd0;
  endtask

  initial begin
    int waited;
    int rv_thr, pop_thr, op;
    logic rv;
    logic [7:0] d;
    logic [7:0] b;

    #2;
    do_reset();

    // Any MMIO access stalls during LEN; non-MMIO accesses never stall.
    dbus_addr = 32'h8000_0002; dbus_re = 1'b1; #1;
    check("len_mmio_stall", {31'd0, dbus_stall}, 32'd1);
    dbus_addr = 32'h0000_0002; #1;
    check("len_nonmmio_stall", {31'd0, dbus_stall}, 32'd0);
    check("len_nonmmio_rd", dbus_rd, 32'd0);
    dbus_re = 1'b0; dbus_addr = 32'd0;
    step();

    // Reset in the middle of LOAD, then boots with N=1, N=0, N=3, and N clamped to MAX_INSTR.
    boot(32'd5, 2, 1'b0);
    do_reset();
    boot(32'd1, 1, 1'b1);
    do_reset();
    boot(32'd0, 0, 1'b1);
    do_reset();
    boot(32'd3, 3, 1'b1);
    do_reset();
    boot(32'h0000_0100, MAX_INSTR, 1'b1);

    // RUN: decode corners.
    dbus_addr = 32'h0000_0001; dbus_re = 1'b1; #1;
    check("run_nonmmio_stall", {31'd0, dbus_stall}, 32'd0);
    check("run_nonmmio_rd", dbus_rd, 32'd0);
    dbus_addr = 32'h8000_0003; #1;
    check("other_off_rd", dbus_rd, 32'd0);
    check("other_off_stall", {31'd0, dbus_stall}, 32'd0);
    dbus_re = 1'b0; dbus_we = 1'b1; dbus_addr = 32'h8000_0005; #1;
    check("other_off_wr_stall", {31'd0, dbus_stall}, 32'd0);
    dbus_we = 1'b0; dbus_addr = 32'd0;
    step();
    rd_check(4'h0, 32'd1, "status_initial");
    rd_check(4'h2, 32'd0, "count_initial");

    // 260 bytes into a 256-entry ring: the 4 oldest are dropped.
    for (int i = 0; i < 260; i++) begin
      b = 8'(i);
      rx_model_push(b);
      send_byte(b);
    end
    rd_check(4'h2, 32'(rxq.size()), "count_after_overflow");
    rd_check(4'h0, {30'd0, sticky, 1'b1}, "status_sticky_set");
    sticky = 1'b0;
    rd_check(4'h0, {30'd0, sticky, 1'b1}, "status_sticky_cleared");
    rd_check(4'h1, {24'd0, rxq[0]}, "first_pop");
    void'(rxq.pop_front());

    // Refill to full, then pop and receive in the same cycle.
    b = 8'($urandom);
    rx_model_push(b);
    send_byte(b);
    rd_check(4'h2, 32'(rxq.size()), "count_refilled");
    d = 8'($urandom);
    dbus_addr = 32'h8000_0001; dbus_re = 1'b1; rx_valid = 1'b1; rx_data = d; #1;
    check("full_pop_rx_rd", dbus_rd, {24'd0, rxq[0]});
    check("full_pop_rx_stall", {31'd0, dbus_stall}, 32'd0);
    step();
    dbus_re = 1'b0; rx_valid = 1'b0; dbus_addr = 32'd0;
    void'(rxq.pop_front());
    rxq.push_back(d);
    rd_check(4'h2, 32'(rxq.size()), "full_pop_rx_count");
    rd_check(4'h0, {30'd0, sticky, 1'b1}, "full_pop_rx_sticky");

    // Random traffic: drain phase reaches empty, then a fill phase overflows.
    for (int i = 0; i < 1400; i++) begin
      rv_thr  = (i < 700) ? 1 : 3;
      pop_thr = (i < 700) ? 3 : 1;
      rv = ($urandom_range(3) < rv_thr);
      d  = 8'($urandom);
      op = ($urandom_range(3) < pop_thr) ? 1 : int'($urandom_range(3));
      rx_valid = rv;
      rx_data  = d;
      dbus_re  = (op != 0);
      dbus_addr = (op == 1) ? 32'h8000_0001 : (op == 2) ? 32'h8000_0002 : 32'h8000_0000;
      #1;
      if (op == 1) begin
        if (rxq.size() == 0 && !rv) begin
          check("rand_pop_stall", {31'd0, dbus_stall}, 32'd1);
        end else begin
          check("rand_pop_stall", {31'd0, dbus_stall}, 32'd0);
          check("rand_pop_rd", dbus_rd, {24'd0, (rxq.size() == 0) ? d : rxq[0]});
        end
      end else if (op == 2) begin
        check("rand_count", dbus_rd, 32'(rxq.size()));
      end else if (op == 3) begin
        check("rand_status", dbus_rd, {30'd0, sticky, 1'b1});
      end
      step();
      if (op == 3) sticky = 1'b0;
      if (op == 1 && rxq.size() == 0 && rv) begin
        // bypassed straight to the core
      end else begin
        if (op == 1 && rxq.size() > 0) void'(rxq.pop_front());
        if (rv) rx_model_push(d);
      end
    end
    rx_valid = 1'b0; dbus_re = 1'b0; dbus_addr = 32'd0;

    // Drain, then hold a pop on an empty ring until a byte arrives.
    while (rxq.size() > 0) begin
      rd_check(4'h1, {24'd0, rxq[0]}, "drain_pop");
      void'(rxq.pop_front());
    end
    dbus_addr = 32'hFFFF_FFF1; dbus_re = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("empty_pop_stall", {31'd0, dbus_stall}, 32'd1);
      step();
    end
    rx_valid = 1'b1; rx_data = 8'hA5; #1;
    check("empty_pop_rd", dbus_rd, 32'h0000_00A5);
    check("empty_pop_release", {31'd0, dbus_stall}, 32'd0);
    step();
    rx_valid = 1'b0; dbus_re = 1'b0; dbus_addr = 32'd0;
    rd_check(4'h2, 32'd0, "empty_pop_count");

    // ---------------- tx path ----------------
    sent_q.delete();
    double_start = 0;
    tx_force = 1'b1;
`ifdef UART_HUB_TX_FIFO_EN
    for (int i = 0; i < TX_DEPTH; i++) begin
      b = 8'($urandom);
      exp_tx.push_back(b);
      mmio_write(4'h4, b, 5, waited);
      check("fifo_push_nostall", 32'(waited), 32'd0);
    end
    rd_check(4'h8, 32'd0, "fifo_space_full");
    b = 8'($urandom);
    exp_tx.push_back(b);
    dbus_addr = 32'h8000_0004; dbus_wd = {24'd0, b}; dbus_we = 1'b1; #1;
    check("fifo_17th_stall", {31'd0, dbus_stall}, 32'd1);
    step(); #1;
    check("fifo_17th_stall_held", {31'd0, dbus_stall}, 32'd1);
    tx_force = 1'b0; #1;
    check("fifo_17th_accept", {31'd0, dbus_stall}, 32'd0);
    step();
    dbus_we = 1'b0; dbus_addr = 32'd0;
    check("tx_start_first", {31'd0, tx_start}, 32'd1);
`else
    b = 8'($urandom);
    exp_tx.push_back(b);
    dbus_addr = 32'h8000_0004; dbus_wd = {24'd0, b}; dbus_we = 1'b1; #1;
    check("hold_busy_stall", {31'd0, dbus_stall}, 32'd1);
    dbus_we = 1'b0; dbus_re = 1'b1; dbus_addr = 32'h8000_0008; #1;
    check("hold_space_busy", dbus_rd, 32'd0);
    dbus_re = 1'b0; dbus_we = 1'b1; dbus_addr = 32'h8000_0004;
    tx_force = 1'b0; #1;
    check("hold_accept", {31'd0, dbus_stall}, 32'd0);
    step();
    dbus_we = 1'b0; dbus_addr = 32'd0;
    check("hold_no_start_yet", {31'd0, tx_start}, 32'd0);
    step();
    check("tx_start_first", {31'd0, tx_start}, 32'd1);
`endif
    check("tx_data_first", {24'd0, tx_data}, {24'd0, exp_tx[0]});

    for (int i = 0; i < 30; i++) begin
      b = 8'($urandom);
      exp_tx.push_back(b);
      mmio_write(4'h4, b, 100, waited);
      if (waited >= 100) check("tx_push_timeout", 32'(waited), 32'd0);
      if ($urandom_range(3) == 0) step();
    end
    waited = 0;
    while (sent_q.size() < exp_tx.size() && waited < 2000) begin
      step();
      waited++;
    end
    check("tx_sent_count", 32'(sent_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < sent_q.size(); i++)
      check("tx_byte", {24'd0, sent_q[i]}, {24'd0, exp_tx[i]});
    check("tx_single_pulse", 32'(double_start), 32'd0);
    waited = 0;
    while (tx_busy && waited < 50) begin
      step();
      waited++;
    end
`ifdef UART_HUB_TX_FIFO_EN
    rd_check(4'h8, 32'(TX_DEPTH), "tx_space_idle");
`else
    rd_check(4'h8, 32'd1, "tx_space_idle");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
